arm_fetch_unit: RTL
===================

# arm_fetch_unit

Instruction-fetch initiator for the ARM pipeline: owns the program counter, drives the address into the combinational instruction memory, and buffers returned words in a 2-entry queue so decode stalls never lose a fetched word. Sits between the instruction memory and the IF/ID register. It accepts branch redirects from EX and presents `{pc+4, instr}` pairs to decode with a valid/ready handshake.

## Interface
- `PC_RESET`, default 32'd0: PC value loaded on reset.
- `QDEPTH`, default 2: queue entries; only 2 is supported.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_pc` out 32: address to instruction memory; equals the PC register, combinational.
- `imem_instr` in 32: instruction memory data, valid in the same cycle as `imem_pc`.
- `branch_taken` in 1: redirect request from EX.
- `branch_addr` in 32: redirect target; must be word-aligned.
- `id_ready` in 1: decode accepts the head entry this cycle (the inverse of the hazard freeze).
- `if_valid` out 1: queue head is valid.
- `if_instr` out 32: head instruction word.
- `if_pc` out 32: head fetch address + 4.
- `halted` out 1: fetch stopped by end-of-program detect (see Configuration).

## Operation
- Registers: `pc`, two queue entries `{pc4, instr}`, occupancy `count` (0..2), `halted`.
- `pop = if_valid & id_ready`.
- `fetch = ~halted & ((count < 2) | pop) & ~branch_taken`.
- On `fetch`, at the clock edge: push `{pc+4, imem_instr}` and set `pc <= pc + 4`. The PC wraps modulo 2^32.
- Simultaneous push and pop at `count == 2`: head advances, new word enters the tail, `count` stays 2.
- Push at `count == 0` with `id_ready == 1`: the word is enqueued and appears next cycle; there is no bypass.
- `branch_taken` has highest priority. At the edge: the queue is cleared (`count <= 0`), `pc <= branch_addr`, `halted <= 0`, and no push occurs. A pop in that same cycle is still considered taken by decode; this is the branch instruction's own slot and is the consumer's responsibility.
- Outputs are driven from the queue head and hold stable while `if_valid & ~id_ready`.
- Reset values: `pc = PC_RESET`, `count = 0`, `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `halted = 0`. `imem_pc = PC_RESET` while in reset.
- Reset asserted mid-operation clears all state immediately and asynchronously; in-flight entries are discarded.

## Timing
- Fetch-to-output latency is 1 cycle: the word addressed in cycle N is at the head in cycle N+1 if the queue was empty.
- Steady state with `id_ready` held high gives 1 instruction per cycle.
- Branch penalty:
  - Cycle B: `branch_taken` is asserted.
  - Cycle B+1: `imem_pc = branch_addr`, `if_valid = 0`.
  - Cycle B+2: target word is at the head.
- Stall: with `id_ready` low, the queue fills in 2 cycles, then `pc` freezes. When `id_ready` rises, the first pop and a new fetch happen in the same cycle.

## Configuration
- `ARM_FETCH_END_DETECT_EN` defined:
  - A fetched word equal to 32'h0000_0000 (the instruction memory's out-of-range default) sets `halted` at that edge.
  - The zero word itself is not pushed, and `pc` does not advance.
  - `halted` is cleared only by reset or `branch_taken`.
- Not defined: zero words are fetched as ordinary instructions (ANDEQ R0,R0,R0), and `halted` is tied to 0.

## Structure
- Shared package `arm_fetch_pkg`:
  - `WORD_W = 32`, `PC_STEP = 32'd4`, `END_WORD = 32'h0`.
  - Typedef `fetch_entry_t {logic [31:0] pc4; logic [31:0] instr;}`.
- One sub-module, `fetch_queue`: 2-entry synchronous FIFO with push, pop, clear, and `count`. It has an async active-low reset and no combinational push-to-head path.

## Test plan
- Reset release, `id_ready = 1`, memory holding the ARM test program: the first edge fetches address 0, and the next cycle shows `if_instr = 0xE3A00014`, `if_pc = 4`. The following cycle shows `0xE3A01A01`, `if_pc = 8`.
- Hold `id_ready = 0` for 5 cycles from `pc = 0`: `count` reaches 2, `imem_pc` freezes at 8, and the head holds 0xE3A00014. Releasing `id_ready` yields `if_pc` 4, 8, 12 on consecutive cycles with no gaps.
- `branch_taken = 1`, `branch_addr = 60` while `count = 2`: the next cycle has `if_valid = 0` and `imem_pc = 60`. The cycle after shows `if_pc = 64`, `if_instr = 0xE3A00B01`.
- Assert `rst_n = 0` mid-stall with `count = 2`: `if_valid` drops immediately without waiting for a clock, and `imem_pc = 0`.
- With `ARM_FETCH_END_DETECT_EN` defined, run to address 72 (returns 0): `halted = 1`, `imem_pc` stays 72, and the last entry presented has `if_pc = 72`. A branch to 0 clears `halted`.
- Without the macro, the same run presents `if_instr = 0` with `if_pc = 76`, and `halted` stays 0.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package arm_fetch_pkg;

    localparam int          WORD_W   = 32;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] END_WORD = 32'h0;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry registered FIFO of fetched {pc+4, instr} pairs
module fetch_queue
    import arm_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    logic [1:0]   cnt;
    fetch_entry_t head_q;
    fetch_entry_t tail_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop & (cnt != 2'd0);
    assign do_push = push & ((cnt != 2'd2) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) head_q <= wdata;
                    else             tail_q <= wdata;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    // Full: head advances and the new word takes the tail slot.
                    if (cnt == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= wdata;
                    end else begin
                        head_q <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = head_q;
    assign valid = (cnt != 2'd0);
    assign count = cnt;

endmodule

// File: rtl/arm_fetch_unit.sv
// rtl/arm_fetch_unit.sv - PC owner and fetch buffer; ARM_FETCH_END_DETECT_EN enables halt on zero word
module arm_fetch_unit
    import arm_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'd0,
    parameter int          QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WORD_W-1:0] imem_pc,
    input  logic [WORD_W-1:0] imem_instr,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_instr,
    output logic [WORD_W-1:0] if_pc,
    output logic              halted
);

    localparam logic [1:0] QFULL = 2'(QDEPTH);

    logic [WORD_W-1:0] pc;
    logic [1:0]        count;
    fetch_entry_t      head;
    fetch_entry_t      wdata;
    logic              pop;
    logic              fetch;
    logic              push;
    logic              end_hit;
    logic              halt_q;

    assign pop   = if_valid & id_ready;
    assign fetch = ~halt_q & ((count < QFULL) | pop) & ~branch_taken;

`ifdef ARM_FETCH_END_DETECT_EN
    // Out-of-range memory reads return zero; treat that as end of program.
    assign end_hit = fetch & (imem_instr == END_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            halt_q <= 1'b0;
        else if (branch_taken) halt_q <= 1'b0;
        else if (end_hit)      halt_q <= 1'b1;
    end
`else
    assign end_hit = 1'b0;
    assign halt_q  = 1'b0;
`endif

    assign push = fetch & ~end_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pc <= PC_RESET;
        else if (branch_taken) pc <= branch_addr;
        else if (push)         pc <= next_pc(pc);
    end

    assign wdata.pc4   = next_pc(pc);
    assign wdata.instr = imem_instr;

    fetch_queue u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (branch_taken),
        .wdata (wdata),
        .head  (head),
        .valid (if_valid),
        .count (count)
    );

    assign imem_pc  = pc;
    assign if_instr = head.instr;
    assign if_pc    = head.pc4;
    assign halted   = halt_q;

endmodule
